// File: rtl/ssio_ddr_out_fwd.sv
// ---------------------------------------------------------------------------
// ssio_ddr_out_fwd
//   Source-synchronous DDR transmitter with a forwarded clock (RGMII-TX style).
//   (d1, d2) word pairs enter through a valid/ready stream into a 2-entry skid
//   FIFO. The FIFO head is launched once per word period. d1 is driven while
//   the forwarded clock is high and d2 while it is low. A programmable divider
//   stretches the word period for 10/100-style rates. When the FIFO runs dry,
//   an idle pattern is driven, and a starve in the middle of a stream is
//   flagged with a one-cycle underflow pulse.
//
// Parameters
//   TARGET     "GENERIC" behavioural DDR output, "XILINX" per-bit ODDR
//              (SAME_EDGE) slice structure for data and forwarded clock
//   WIDTH      data bits per edge
//   IDLE_D1/2  words driven in the high/low phase while starved
//   DIV_WIDTH  width of cfg_div
//   CNT_WIDTH  width of the saturating underflow counter
//
// Ports
//   clk, rst_n       logic/IO clock, asynchronous active-low reset
//   s_d1, s_d2       high-phase / low-phase data of one word
//   s_valid, s_ready stream handshake (s_ready is registered)
//   cfg_div          0 = one word per clk, N = one word per N+1 clks
//   output_clk       forwarded clock
//   output_q         DDR data
//   underflow        one-cycle pulse when a running stream starves
//   underflow_count  saturating starve count
//
// Build option
//   SSIO_DDR_OUT_UNDERFLOW_CNT_EN  when defined, underflow_count counts the
//                                  underflow pulses (cleared by reset only).
//                                  Otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module ssio_ddr_out_fwd #(
    parameter string           TARGET    = "GENERIC",
    parameter int              WIDTH     = 5,
    parameter logic [WIDTH-1:0] IDLE_D1  = '0,
    parameter logic [WIDTH-1:0] IDLE_D2  = '0,
    parameter int              DIV_WIDTH = 8,
    parameter int              CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     s_d1,
    input  logic [WIDTH-1:0]     s_d2,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    output logic                 output_clk,
    output logic [WIDTH-1:0]     output_q,
    output logic                 underflow,
    output logic [CNT_WIDTH-1:0] underflow_count
);

    // Skid FIFO
    logic [WIDTH-1:0] mem_d1 [2];
    logic [WIDTH-1:0] mem_d2 [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    // Word timing and launch registers
    logic [DIV_WIDTH-1:0] ph;
    logic [DIV_WIDTH-1:0] div_r;
    logic [WIDTH-1:0]     q1_r;
    logic [WIDTH-1:0]     q2_r;
    logic                 in_stream;
    logic                 run;
    logic                 s_ready_r;
    logic                 underflow_r;

    logic       push;
    logic       pop;
    logic       boundary;
    logic       starve;
    logic [1:0] count_next;

    assign push       = s_valid && s_ready_r;
    assign boundary   = (ph == div_r);
    assign pop        = boundary && (count != 2'd0);
    assign starve     = boundary && (count == 2'd0) && in_stream;
    assign count_next = count + 2'(push) - 2'(pop);

    assign s_ready   = s_ready_r;
    assign underflow = underflow_r;

    // NOTE: the FIFO storage has no reset; occupancy and pointers are reset,
    // so stale entries can never be read and the array maps to plain flops/LUTRAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_d1[wr_ptr] <= s_d1;
            mem_d2[wr_ptr] <= s_d2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            s_ready_r   <= 1'b0;
            ph          <= '0;
            div_r       <= '0;
            q1_r        <= '0;
            q2_r        <= '0;
            in_stream   <= 1'b0;
            underflow_r <= 1'b0;
            run         <= 1'b0;
        end else begin
            run         <= 1'b1;
            count       <= count_next;
            // Ready for the next cycle already accounts for a same-cycle pop.
            s_ready_r   <= (count_next != 2'd2);
            underflow_r <= starve;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (boundary) begin
                // The divider only moves on word boundaries, so a word never
                // changes period while it is on the wire.
                ph    <= '0;
                div_r <= cfg_div;
                if (pop) begin
                    q1_r      <= mem_d1[rd_ptr];
                    q2_r      <= mem_d2[rd_ptr];
                    in_stream <= 1'b1;
                end else begin
                    q1_r      <= IDLE_D1;
                    q2_r      <= IDLE_D2;
                    in_stream <= 1'b0;
                end
            end else begin
                ph <= ph + DIV_WIDTH'(1);
            end
        end
    end

    // Forwarded-clock shape. Full rate: high in the clk-high half, low in the
    // clk-low half. Divided: high for the first ceil((D+1)/2) clks of a word,
    // i.e. while ph <= D/2, on both clk halves.
    logic first_half;
    logic clk_hi_phase;
    logic clk_lo_phase;
    logic [WIDTH-1:0] hi_word;
    logic [WIDTH-1:0] lo_word;

    assign first_half   = (ph <= (div_r >> 1));
    assign clk_hi_phase = run && first_half;
    assign clk_lo_phase = run && (div_r != '0) && first_half;
    assign hi_word      = first_half ? q1_r : q2_r;
    assign lo_word      = ((div_r != '0) && first_half) ? q1_r : q2_r;

    generate
        if (TARGET == "XILINX") begin : g_xilinx
            // One SAME_EDGE DDR slice per data bit plus one for the clock:
            // D1 drives the clk-high half, D2 is retimed to the falling edge
            // and drives the clk-low half.
            for (genvar b = 0; b <= WIDTH; b++) begin : g_oddr
                logic d1;
                logic d2;
                logic d2_n;
                if (b < WIDTH) begin : g_data
                    assign d1 = hi_word[b];
                    assign d2 = lo_word[b];
                    assign output_q[b] = clk ? d1 : d2_n;
                end else begin : g_clk
                    assign d1 = clk_hi_phase;
                    assign d2 = clk_lo_phase;
                    assign output_clk = clk ? d1 : d2_n;
                end
                always_ff @(negedge clk or negedge rst_n) begin
                    if (!rst_n) d2_n <= 1'b0;
                    else        d2_n <= d2;
                end
            end
        end else begin : g_generic
            logic [WIDTH-1:0] lo_q_n;
            logic             lo_clk_n;
            // The low-half values are retimed on the falling edge so the
            // output mux only ever selects between stable registers.
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lo_q_n   <= '0;
                    lo_clk_n <= 1'b0;
                end else begin
                    lo_q_n   <= lo_word;
                    lo_clk_n <= clk_lo_phase;
                end
            end
            // NOTE: clk selects between the two half-cycle values here; this is
            // the behavioural DDR output, not a gated clock feeding any flop.
            assign output_clk = clk ? clk_hi_phase : lo_clk_n;
            assign output_q   = clk ? hi_word : lo_q_n;
        end
    endgenerate

`ifdef SSIO_DDR_OUT_UNDERFLOW_CNT_EN
    logic [CNT_WIDTH-1:0] uf_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          uf_cnt <= '0;
        else if (starve && (uf_cnt != '1))   uf_cnt <= uf_cnt + CNT_WIDTH'(1);
    end
    assign underflow_count = uf_cnt;
`else
    assign underflow_count = '0;
`endif

endmodule

// File: tb/tb_ssio_ddr_out_fwd.sv
// ---------------------------------------------------------------------------
// tb_ssio_ddr_out_fwd
//   Directed bench for ssio_ddr_out_fwd: reset/idle, full-rate streaming,
//   divided rate with a mid-word cfg_div change, backpressure with a
//   scoreboard, reset mid-stream and the underflow counter.
//   Outputs are sampled 2 ns after each clk edge (high half / low half).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ssio_ddr_out_fwd;

    localparam int         WIDTH     = 5;
    localparam int         DIV_WIDTH = 8;
    localparam int         CNT_WIDTH = 2;
    localparam logic [4:0] IDLE1     = 5'h1C;
    localparam logic [4:0] IDLE2     = 5'h1D;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [WIDTH-1:0]     s_d1;
    logic [WIDTH-1:0]     s_d2;
    logic                 s_valid;
    logic                 s_ready;
    logic [DIV_WIDTH-1:0] cfg_div;
    logic                 output_clk;
    logic [WIDTH-1:0]     output_q;
    logic                 underflow;
    logic [CNT_WIDTH-1:0] underflow_count;

    int total = 0;
    int bad   = 0;

    ssio_ddr_out_fwd #(
        .TARGET    ("GENERIC"),
        .WIDTH     (WIDTH),
        .IDLE_D1   (IDLE1),
        .IDLE_D2   (IDLE2),
        .DIV_WIDTH (DIV_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_d1            (s_d1),
        .s_d2            (s_d2),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .cfg_div         (cfg_div),
        .output_clk      (output_clk),
        .output_q        (output_q),
        .underflow       (underflow),
        .underflow_count (underflow_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // High-half sample point: 2 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Low-half sample point: 2 ns after the falling edge.
    task automatic low();
        #5;
    endtask

    function automatic int exp_count(input int events);
`ifdef SSIO_DDR_OUT_UNDERFLOW_CNT_EN
        return (events > 3) ? 3 : events;
`else
        return 0;
`endif
    endfunction

    logic [9:0] words [3] = '{{5'h15, 5'h16}, {5'h17, 5'h18}, {5'h19, 5'h1A}};
    logic [9:0] sb [$];
    logic [9:0] cur;
    logic       acc;
    int         n_acc;
    int         ready_exp [12] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1};
    logic       d3_clk    [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [4:0] d3_q      [4]  = '{5'h0A, 5'h0A, 5'h05, 5'h05};

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_d1 = '0; s_d2 = '0; cfg_div = '0;
        cur = '0; acc = 1'b0; n_acc = 0;

        // ---- reset state ----
        #3;
        check("rst_ready", s_ready, 0);
        check("rst_oclk_lo", output_clk, 0);
        check("rst_q_lo", output_q, 0);
        check("rst_uf", underflow, 0);
        check("rst_cnt", underflow_count, 0);
        @(posedge clk); #2;
        check("rst_oclk_hi", output_clk, 0);
        check("rst_q_hi", output_q, 0);
        #5 rst_n = 1'b1;

        // ---- idle at full rate ----
        for (int i = 0; i < 2; i++) begin
            tick();
            check("idle_ready", s_ready, 1);
            check("idle_oclk_hi", output_clk, 1);
            check("idle_q_hi", output_q, IDLE1);
            check("idle_uf", underflow, 0);
            low();
            check("idle_oclk_lo", output_clk, 0);
            check("idle_q_lo", output_q, IDLE2);
        end

        // ---- full-rate stream, back-to-back ----
        s_valid = 1'b1; s_d1 = 5'h01; s_d2 = 5'h02;
        tick();
        check("fr_first_idle", output_q, IDLE1);
        s_d1 = 5'h03; s_d2 = 5'h04;
        tick(); check("fr_q01", output_q, 5'h01);
        check("fr_oclk_hi", output_clk, 1);
        s_d1 = 5'h05; s_d2 = 5'h06;
        low();  check("fr_q02", output_q, 5'h02);
        check("fr_oclk_lo", output_clk, 0);
        tick(); check("fr_q03", output_q, 5'h03);
        s_valid = 1'b0;
        low();  check("fr_q04", output_q, 5'h04);
        tick(); check("fr_q05", output_q, 5'h05);
        check("fr_no_uf", underflow, 0);
        low();  check("fr_q06", output_q, 5'h06);
        tick(); check("fr_uf", underflow, 1);
        check("fr_cnt1", underflow_count, exp_count(1));
        check("fr_idle_hi", output_q, IDLE1);
        low();  check("fr_idle_lo", output_q, IDLE2);
        tick(); check("fr_uf_once", underflow, 0);
        low();

        // ---- cfg_div=3, single word, then change to 1 mid-word ----
        cfg_div = 8'd3; s_valid = 1'b1; s_d1 = 5'h0A; s_d2 = 5'h05;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            check("d3_oclk_hi", output_clk, d3_clk[i]);
            check("d3_q_hi", output_q, d3_q[i]);
            if (i == 0) cfg_div = 8'd1;
            low();
            check("d3_oclk_lo", output_clk, d3_clk[i]);
            check("d3_q_lo", output_q, d3_q[i]);
        end
        tick();
        check("d1_uf", underflow, 1);
        check("d1_cnt2", underflow_count, exp_count(2));
        check("d1_ph0_oclk_hi", output_clk, 1);
        check("d1_ph0_q_hi", output_q, IDLE1);
        low();
        check("d1_ph0_oclk_lo", output_clk, 1);
        check("d1_ph0_q_lo", output_q, IDLE1);
        tick();
        check("d1_ph1_oclk_hi", output_clk, 0);
        check("d1_ph1_q_hi", output_q, IDLE2);
        check("d1_ph1_uf", underflow, 0);
        low();
        check("d1_ph1_oclk_lo", output_clk, 0);
        check("d1_ph1_q_lo", output_q, IDLE2);

        // ---- backpressure at cfg_div=4 with scoreboard ----
        cfg_div = 8'd4; s_valid = 1'b1; {s_d1, s_d2} = words[0];
        for (int c = 0; c < 22; c++) begin
            acc = s_valid && s_ready;
            tick();
            if (acc) begin
                sb.push_back({s_d1, s_d2});
                n_acc++;
                if (n_acc < 3) {s_d1, s_d2} = words[n_acc];
                else s_valid = 1'b0;
            end
            if (c < 12) check("bp_ready", s_ready, ready_exp[c]);
            if (c == 5 || c == 10 || c == 15) begin
                check("bp_sb_nonempty", (sb.size() != 0), 1);
                if (sb.size() != 0) cur = sb.pop_front();
                check("bp_d1", output_q, cur[9:5]);
                check("bp_oclk_hi", output_clk, 1);
            end
            if (c == 20) begin
                check("bp_uf", underflow, 1);
                check("bp_cnt3", underflow_count, exp_count(3));
            end
            low();
            if (c == 8 || c == 13 || c == 18) begin
                check("bp_d2", output_q, cur[4:0]);
                check("bp_oclk_lo", output_clk, 0);
            end
        end
        check("bp_accepted", n_acc, 3);
        check("bp_sb_drained", sb.size(), 0);

        // ---- reset with two words buffered ----
        s_valid = 1'b1; s_d1 = 5'h0F; s_d2 = 5'h0E;
        tick();
        s_d1 = 5'h0D; s_d2 = 5'h0C;
        tick();
        s_valid = 1'b0;
        check("mr_full", s_ready, 0);
        #1 rst_n = 1'b0;
        #1;
        check("mr_oclk", output_clk, 0);
        check("mr_q", output_q, 0);
        check("mr_ready", s_ready, 0);
        cfg_div = '0;
        @(negedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mr_post_ready", s_ready, 1);
            check("mr_post_q_hi", output_q, IDLE1);
            check("mr_post_oclk", output_clk, 1);
            check("mr_post_uf", underflow, 0);
            check("mr_post_cnt", underflow_count, 0);
            low();
            check("mr_post_q_lo", output_q, IDLE2);
        end

        // ---- five starve events: saturating counter ----
        for (int e = 1; e <= 5; e++) begin
            s_valid = 1'b1; s_d1 = 5'(e); s_d2 = 5'(e + 8);
            tick();
            s_valid = 1'b0;
            tick();
            check("uc_word", output_q, 5'(e));
            tick();
            check("uc_uf", underflow, 1);
            check("uc_cnt", underflow_count, exp_count(e));
            low();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
